key_mode_ctrl: RTL and testbench

- Front-end controller for the 4-key / 4-LED board path.
- Synchronises and debounces the four active-low keys, turns presses into single-cycle events, and runs a mode state machine.
- Drives a step timer and LED pattern sequencer from the current mode.
- Replaces the level-sensitive "hold key to show pattern" scheme with latched, toggle-style modes.

---
 rtl/key_mode_ctrl.sv | 147 ++++++++++++++
 tb/tb_key_mode_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/key_mode_ctrl.sv
// rtl/key_mode_ctrl.sv - key sync/debounce, toggle-mode FSM, step timer and LED sequencer
// Optional idle auto-off enabled by defining KEY_MODE_AUTO_OFF_EN.
module key_mode_ctrl #(
  parameter int DEB_CYC        = 1_000_000,
  parameter int STEP_CYC       = 10_000_000,
  parameter int AUTO_OFF_STEPS = 50
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] key,
  output logic [3:0] key_press,
  output logic [2:0] mode,
  output logic       step_tick,
  output logic [3:0] led
);

  localparam int DW = $clog2(DEB_CYC);
  localparam int SW = $clog2(STEP_CYC);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT_L = 3'd1,
    SHIFT_R = 3'd2,
    BLINK   = 3'd3,
    ALL_ON  = 3'd4
  } mode_e;

  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    deb_q, deb_d, deb_prev_q;
  logic [DW-1:0] deb_cnt_q [4];
  logic [DW-1:0] deb_cnt_d [4];
  logic [3:0]    key_press_q;
  mode_e         mode_q, mode_d, tgt;
  logic [SW-1:0] step_cnt_q;
  logic [1:0]    phase_q;
  logic [3:0]    led_q, led_d;
  logic          tick;

  // A key level is accepted only after DEB_CYC consecutive cycles of disagreement.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DW'(DEB_CYC - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q     <= 4'hf;
      sync2_q     <= 4'hf;
      deb_q       <= 4'hf;
      deb_prev_q  <= 4'hf;
      key_press_q <= 4'h0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q     <= key;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_q;
      key_press_q <= deb_prev_q & ~deb_q;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  assign tick = (mode_q != IDLE) && (step_cnt_q == SW'(STEP_CYC - 1));

`ifdef KEY_MODE_AUTO_OFF_EN
  localparam int IW = $clog2(AUTO_OFF_STEPS + 1);
  logic [IW-1:0] idle_cnt_q;
  logic          idle_hit;

  assign idle_hit = tick && (idle_cnt_q == IW'(AUTO_OFF_STEPS - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idle_cnt_q <= '0;
    end else if ((|key_press_q) || (mode_d != mode_q)) begin
      idle_cnt_q <= '0;
    end else if (tick) begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end
`endif

  // Lowest key index wins; pressing the active mode's key toggles back to IDLE.
  always_comb begin
    mode_d = mode_q;
    tgt    = IDLE;
    if (key_press_q[0])      tgt = SHIFT_L;
    else if (key_press_q[1]) tgt = SHIFT_R;
    else if (key_press_q[2]) tgt = BLINK;
    else if (key_press_q[3]) tgt = ALL_ON;
    if (|key_press_q) begin
      mode_d = (tgt == mode_q) ? IDLE : tgt;
    end
`ifdef KEY_MODE_AUTO_OFF_EN
    else if (idle_hit) begin
      mode_d = IDLE;
    end
`endif
  end

  always_comb begin
    led_d = 4'h0;
    case (mode_q)
      SHIFT_L: led_d = 4'b0001 << phase_q;
      SHIFT_R: led_d = 4'b1000 >> phase_q;
      BLINK:   led_d = phase_q[0] ? 4'h0 : 4'hf;
      ALL_ON:  led_d = 4'hf;
      default: led_d = 4'h0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q     <= IDLE;
      step_cnt_q <= '0;
      phase_q    <= 2'd0;
      led_q      <= 4'h0;
    end else begin
      mode_q <= mode_d;
      led_q  <= led_d;
      if ((mode_q == IDLE) || (mode_d != mode_q)) begin
        step_cnt_q <= '0;
        phase_q    <= 2'd0;
      end else if (tick) begin
        step_cnt_q <= '0;
        phase_q    <= phase_q + 2'd1;
      end else begin
        step_cnt_q <= step_cnt_q + 1'b1;
      end
    end
  end

  assign key_press = key_press_q;
  assign mode      = mode_q;
  assign step_tick = tick;
  assign led       = led_q;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// tb/tb_key_mode_ctrl.sv - directed self-checking bench for key_mode_ctrl
module tb_key_mode_ctrl;
  localparam int DEB  = 4;
  localparam int STEP = 8;
  localparam int AO   = 50;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] key = 4'hf;
  logic [3:0] key_press;
  logic [2:0] mode;
  logic       step_tick;
  logic [3:0] led;

  int n_tests = 0;
  int n_fail  = 0;

  key_mode_ctrl #(
    .DEB_CYC(DEB),
    .STEP_CYC(STEP),
    .AUTO_OFF_STEPS(AO)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .key(key),
    .key_press(key_press),
    .mode(mode),
    .step_tick(step_tick),
    .led(led)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic press(input logic [3:0] m);
    int c = 0;
    key = ~m;
    while (key_press == 4'h0 && c < 20) begin
      tick();
      c++;
    end
    check("press_mask", {28'h0, key_press}, {28'h0, m});
  endtask

  task automatic release_keys();
    logic [3:0] acc = 4'h0;
    key = 4'hf;
    for (int i = 0; i < 12; i++) begin
      tick();
      acc |= key_press;
    end
    check("release_no_event", {28'h0, acc}, 32'h0);
  endtask

  initial begin
    logic [3:0] acc;
    logic       st;

    sys_rst_n = 1'b0;
    key = 4'hf;
    tick(3);
    check("rst_led", {28'h0, led}, 32'h0);
    check("rst_mode", {29'h0, mode}, 32'h0);
    check("rst_key_press", {28'h0, key_press}, 32'h0);
    check("rst_step_tick", {31'h0, step_tick}, 32'h0);
    sys_rst_n = 1'b1;

    acc = 4'h0;
    st  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      acc |= key_press;
      st  |= step_tick;
    end
    check("idle_no_press", {28'h0, acc}, 32'h0);
    check("idle_no_tick", {31'h0, st}, 32'h0);
    check("idle_led", {28'h0, led}, 32'h0);
    check("idle_mode", {29'h0, mode}, 32'h0);

    key = 4'b1110;
    tick(3);
    key = 4'hf;
    acc = 4'h0;
    for (int i = 0; i < 20; i++) begin
      tick();
      acc |= key_press;
    end
    check("glitch_no_press", {28'h0, acc}, 32'h0);
    check("glitch_mode", {29'h0, mode}, 32'h0);

    // sync 2 + debounce 4 + press register 1 = press visible 7 edges after the pin falls
    key = 4'b1110;
    tick(6);
    check("press_not_early", {28'h0, key_press}, 32'h0);
    tick();
    check("press_key0", {28'h0, key_press}, 32'h1);
    tick();
    check("press_one_cycle", {28'h0, key_press}, 32'h0);
    check("mode_shift_l", {29'h0, mode}, 32'h1);
    tick();
    check("shl_led_p0", {28'h0, led}, 32'h1);
    tick(5);
    check("step_tick_low", {31'h0, step_tick}, 32'h0);
    tick();
    check("step_tick_high", {31'h0, step_tick}, 32'h1);
    tick();
    check("step_tick_pulse", {31'h0, step_tick}, 32'h0);
    tick();
    check("shl_led_p1", {28'h0, led}, 32'h2);
    tick(8);
    check("shl_led_p2", {28'h0, led}, 32'h4);
    tick(8);
    check("shl_led_p3", {28'h0, led}, 32'h8);
    tick(8);
    check("shl_led_wrap", {28'h0, led}, 32'h1);
    release_keys();

    press(4'b0001);
    tick();
    check("toggle_off_mode", {29'h0, mode}, 32'h0);
    tick();
    check("toggle_off_led", {28'h0, led}, 32'h0);
    release_keys();

    press(4'b0100);
    tick();
    check("blink_mode", {29'h0, mode}, 32'h3);
    tick();
    check("blink_led_p0", {28'h0, led}, 32'hf);
    tick(8);
    check("blink_led_p1", {28'h0, led}, 32'h0);
    tick(8);
    check("blink_led_p2", {28'h0, led}, 32'hf);
    release_keys();

    press(4'b0100);
    tick();
    check("blink_off_mode", {29'h0, mode}, 32'h0);
    release_keys();

    press(4'b1110);
    tick();
    check("multi_mode", {29'h0, mode}, 32'h2);
    tick();
    check("multi_led", {28'h0, led}, 32'h8);
    tick(4);
    check("multi_mode_stable", {29'h0, mode}, 32'h2);
    release_keys();

    press(4'b1000);
    tick();
    check("all_on_mode", {29'h0, mode}, 32'h4);
    tick();
    check("all_on_led0", {28'h0, led}, 32'hf);
    tick(8);
    check("all_on_led1", {28'h0, led}, 32'hf);
    tick(8);
    check("all_on_led2", {28'h0, led}, 32'hf);
    release_keys();

    press(4'b0100);
    tick();
    check("switch_to_blink", {29'h0, mode}, 32'h3);
    tick(3);
    check("blink_before_rst", {28'h0, led}, 32'hf);
    #3 sys_rst_n = 1'b0;
    #1;
    check("async_rst_led", {28'h0, led}, 32'h0);
    check("async_rst_mode", {29'h0, mode}, 32'h0);
    key = 4'hf;
    tick(2);
    sys_rst_n = 1'b1;
    acc = 4'h0;
    for (int i = 0; i < 20; i++) begin
      tick();
      acc |= key_press;
    end
    check("post_rst_no_press", {28'h0, acc}, 32'h0);
    check("post_rst_mode", {29'h0, mode}, 32'h0);

`ifdef KEY_MODE_AUTO_OFF_EN
    press(4'b1000);
    tick(STEP * AO);
    check("ao_last_tick", {31'h0, step_tick}, 32'h1);
    check("ao_mode_before", {29'h0, mode}, 32'h4);
    tick();
    check("ao_mode_idle", {29'h0, mode}, 32'h0);
    check("ao_led_still_on", {28'h0, led}, 32'hf);
    tick();
    check("ao_led_off", {28'h0, led}, 32'h0);
    release_keys();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
